// File: rtl/dmi_arbiter_if.sv
// DMI link bundle: one request channel plus one response channel, both valid/ready.
// master drives requests and consumes responses; slave is the opposite side.
// Signal names mirror the DMI bus fields (req_bits_addr/op/data, resp_bits_resp/data).
interface dmi_arbiter_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic [6:0]            req_bits_addr;
    logic [1:0]            req_bits_op;
    logic [DATA_WIDTH-1:0] req_bits_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [1:0]            resp_bits_resp;
    logic [DATA_WIDTH-1:0] resp_bits_data;

    modport master (
        output req_valid, req_bits_addr, req_bits_op, req_bits_data, resp_ready,
        input  req_ready, resp_valid, resp_bits_resp, resp_bits_data
    );

    modport slave (
        input  req_valid, req_bits_addr, req_bits_op, req_bits_data, resp_ready,
        output req_ready, resp_valid, resp_bits_resp, resp_bits_data
    );
endinterface

// File: rtl/dmi_arbiter.sv
// Two-requester DMI arbiter: round-robin grant, one transaction outstanding, response routed back.
// Latency: grant -> debug_req_valid next cycle; downstream response -> rN_resp_valid next cycle.
// Backpressure: requests/responses are held stable until the receiver's ready; no new grant until delivery.
//
// Ports:
//   clk, reset_n : single clock, asynchronous active-low reset
//   r0, r1       : requester links (slave side): request in, response out
//   debug        : downstream DMI link (master side): request out, response in
// Optional build macro DMI_ARB_TIMEOUT_EN: bounds WAIT to TIMEOUT_CYCLES and then
// returns resp=2'b10/data=0; debug_resp_ready is also raised in IDLE to drain late responses.
module dmi_arbiter #(
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           reset_n,
    dmi_arbiter_if.slave   r0,
    dmi_arbiter_if.slave   r1,
    dmi_arbiter_if.master  debug
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DELIVER
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_gnt;   // requester granted most recently
    logic                  r_gnt;        // requester owning the current transaction
    logic [6:0]            r_addr;
    logic [1:0]            r_op;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_resp;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_any;
    logic                  w_pick;
    logic                  w_grant;
    logic                  w_resp_fire;
    logic                  w_timeout;

    assign w_any = r0.req_valid | r1.req_valid;
    // On contention the requester not granted last wins; otherwise the lone requester.
    assign w_pick = (r0.req_valid & r1.req_valid) ? ~r_last_gnt : ~r0.req_valid;
    // Gated by reset_n so no ready can leak out while reset is asserted.
    assign w_grant = reset_n & (r_state == ST_IDLE) & w_any;
    assign w_resp_fire = r_gnt ? r1.resp_ready : r0.resp_ready;

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_tmo_cnt;

    // A response arriving on the last allowed cycle still wins over the timeout.
    assign w_timeout = (r_state == ST_WAIT) & ~debug.resp_valid &
                       (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_ISSUE) && debug.req_ready) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    // TIMEOUT_CYCLES is kept so both builds share one parameter list.
    if (TIMEOUT_CYCLES > 0) begin : g_no_timeout
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        r0.req_ready      = 1'b0;
        r1.req_ready      = 1'b0;
        debug.req_valid   = 1'b0;
        debug.resp_ready  = 1'b0;
        r0.resp_valid     = 1'b0;
        r1.resp_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                r0.req_ready = w_grant & ~w_pick;
                r1.req_ready = w_grant & w_pick;
`ifdef DMI_ARB_TIMEOUT_EN
                // Swallow stale responses from a transaction that already timed out.
                debug.resp_ready = reset_n;
`endif
                if (w_grant) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                debug.req_valid = 1'b1;
                if (debug.req_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                debug.resp_ready = 1'b1;
                if (debug.resp_valid || w_timeout) begin
                    w_state_nxt = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                r0.resp_valid = ~r_gnt;
                r1.resp_valid = r_gnt;
                if (w_resp_fire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_gnt <= 1'b1;
            r_gnt      <= 1'b0;
            r_addr     <= '0;
            r_op       <= '0;
            r_wdata    <= '0;
            r_resp     <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_grant) begin
                r_gnt      <= w_pick;
                r_last_gnt <= w_pick;
                r_addr     <= w_pick ? r1.req_bits_addr : r0.req_bits_addr;
                r_op       <= w_pick ? r1.req_bits_op   : r0.req_bits_op;
                r_wdata    <= w_pick ? r1.req_bits_data : r0.req_bits_data;
            end
            if ((r_state == ST_WAIT) && debug.resp_valid) begin
                r_resp  <= debug.resp_bits_resp;
                r_rdata <= debug.resp_bits_data;
            end else if (w_timeout) begin
                r_resp  <= 2'b10;
                r_rdata <= '0;
            end
        end
    end

    assign debug.req_bits_addr = r_addr;
    assign debug.req_bits_op   = r_op;
    assign debug.req_bits_data = r_wdata;
    assign r0.resp_bits_resp   = r_resp;
    assign r0.resp_bits_data   = r_rdata;
    assign r1.resp_bits_resp   = r_resp;
    assign r1.resp_bits_data   = r_rdata;
endmodule

// File: tb/tb_dmi_arbiter.sv
// Self-checking bench for dmi_arbiter: random requesters and downstream responder
// checked cycle by cycle against a transaction-level model, plus directed scenarios.
// Inputs driven 1ns after posedge, outputs sampled at negedge.
module tb_dmi_arbiter;
    localparam int DW = 64;
    localparam int TO = 8;
`ifdef DMI_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;

    dmi_arbiter_if #(.DATA_WIDTH(DW)) r0_if ();
    dmi_arbiter_if #(.DATA_WIDTH(DW)) r1_if ();
    dmi_arbiter_if #(.DATA_WIDTH(DW)) dbg_if ();

    dmi_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .r0      (r0_if),
        .r1      (r1_if),
        .debug   (dbg_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // stimulus knobs
    int p_v[2];
    int p_drop;
    bit fixed0, no_resp, rnd_stall, force_rsp;
    int dn_fix, rr_fix, lat_fix;
    int lat_max = 4;

    // stimulus state
    bit          vld[2];
    logic [6:0]  q_addr[2];
    logic [1:0]  q_op[2];
    logic [63:0] q_data[2];
    int          dn_cnt, dn_stall, rsp_cnt;
    int          rr_cnt[2], rr_stall[2];
    bit          rsp_pend;
    logic [1:0]  rsp_resp, frc_resp;
    logic [63:0] rsp_data, frc_data;
    bit          drv_dn_rdy, drv_rsp_v;
    bit          drv_rr[2];

    // reference model: one transaction in flight, phases granted -> issued -> answered
    bit          busy, dfired, rspfired;
    int          cur, last_gnt, dfire_cyc;
    logic [6:0]  e_addr;
    logic [1:0]  e_op, e_resp;
    logic [63:0] e_data, e_rdata;
    int          grants[$];
    int          ndeliv, obs_who;
    logic [1:0]  obs_resp;
    logic [63:0] obs_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive_inputs();
        r0_if.req_valid      = vld[0];
        r0_if.req_bits_addr  = q_addr[0];
        r0_if.req_bits_op    = q_op[0];
        r0_if.req_bits_data  = q_data[0];
        r0_if.resp_ready     = drv_rr[0];
        r1_if.req_valid      = vld[1];
        r1_if.req_bits_addr  = q_addr[1];
        r1_if.req_bits_op    = q_op[1];
        r1_if.req_bits_data  = q_data[1];
        r1_if.resp_ready     = drv_rr[1];
        dbg_if.req_ready     = drv_dn_rdy;
        dbg_if.resp_valid    = drv_rsp_v;
        dbg_if.resp_bits_resp = force_rsp ? frc_resp : rsp_resp;
        dbg_if.resp_bits_data = force_rsp ? frc_data : rsp_data;
    endtask

    task automatic set_fix(input int dn, input int rr, input int lat);
        rnd_stall   = 1'b0;
        dn_fix      = dn;
        rr_fix      = rr;
        lat_fix     = lat;
        dn_stall    = dn;
        rr_stall[0] = rr;
        rr_stall[1] = rr;
    endtask

    // Asserts reset immediately (asynchronously) and checks outputs go quiet at once.
    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_req_rdy0", r0_if.req_ready, 0);
        chk("rst_req_rdy1", r1_if.req_ready, 0);
        chk("rst_resp_vld0", r0_if.resp_valid, 0);
        chk("rst_resp_vld1", r1_if.resp_valid, 0);
        chk("rst_dreq_vld", dbg_if.req_valid, 0);
        chk("rst_dresp_rdy", dbg_if.resp_ready, 0);
        chk("rst_dreq_addr", dbg_if.req_bits_addr, 0);
        chk("rst_dreq_op", dbg_if.req_bits_op, 0);
        chk("rst_dreq_data", dbg_if.req_bits_data, 0);
        chk("rst_resp0", {r0_if.resp_bits_resp, r0_if.resp_bits_data[31:0]}, 0);
        chk("rst_resp1_data", r1_if.resp_bits_data, 0);
        vld[0] = 0; vld[1] = 0;
        drv_dn_rdy = 0; drv_rsp_v = 0; drv_rr[0] = 0; drv_rr[1] = 0;
        force_rsp = 0; rsp_pend = 0; dn_cnt = 0; rr_cnt[0] = 0; rr_cnt[1] = 0;
        busy = 0; dfired = 0; rspfired = 0; last_gnt = 1;
        drive_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic step();
        bit busy_pre, w_st, any, ev;
        int who;
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (vld[n] && $urandom_range(99) < p_drop) begin
                vld[n] = 0;
            end else if (!vld[n] && $urandom_range(99) < p_v[n]) begin
                vld[n] = 1;
                if (n == 0 && fixed0) begin
                    q_addr[n] = 7'h11; q_op[n] = 2'd1; q_data[n] = 64'h0;
                end else begin
                    q_addr[n] = 7'($urandom); q_op[n] = 2'($urandom);
                    q_data[n] = {$urandom, $urandom};
                end
            end
        end
        drv_dn_rdy = (dn_cnt >= dn_stall);
        drv_rr[0]  = (rr_cnt[0] >= rr_stall[0]);
        drv_rr[1]  = (rr_cnt[1] >= rr_stall[1]);
        drv_rsp_v  = (rsp_pend && rsp_cnt == 0) || force_rsp;
        if (rsp_pend && rsp_cnt > 0) rsp_cnt--;
        drive_inputs();

        @(negedge clk);
        cyc++;
        busy_pre = busy;
        any = vld[0] | vld[1];
        who = (vld[0] && vld[1]) ? 1 - last_gnt : (vld[0] ? 0 : 1);
        chk("req_rdy0", r0_if.req_ready, !busy && any && who == 0);
        chk("req_rdy1", r1_if.req_ready, !busy && any && who == 1);
        chk("dreq_vld", dbg_if.req_valid, busy && !dfired);
        if (busy && !dfired) begin
            chk("dreq_addr", dbg_if.req_bits_addr, e_addr);
            chk("dreq_op", dbg_if.req_bits_op, e_op);
            chk("dreq_data", dbg_if.req_bits_data, e_data);
        end
        w_st = busy && dfired && !rspfired;
        chk("dresp_rdy", dbg_if.resp_ready, w_st ? 1'b1 : (!busy ? TO_EN : 1'b0));
        ev = busy && rspfired && cur == 0;
        chk("resp_vld0", r0_if.resp_valid, ev);
        if (ev) begin
            chk("resp0_code", r0_if.resp_bits_resp, e_resp);
            chk("resp0_data", r0_if.resp_bits_data, e_rdata);
        end
        ev = busy && rspfired && cur == 1;
        chk("resp_vld1", r1_if.resp_valid, ev);
        if (ev) begin
            chk("resp1_code", r1_if.resp_bits_resp, e_resp);
            chk("resp1_data", r1_if.resp_bits_data, e_rdata);
        end

        // advance the model and the stimulus agents
        if (busy && !dfired) begin
            if (drv_dn_rdy) begin
                dfired = 1; dfire_cyc = cyc; dn_cnt = 0;
                dn_stall = rnd_stall ? $urandom_range(3) : dn_fix;
                if (!no_resp) begin
                    rsp_pend = 1;
                    rsp_cnt  = rnd_stall ? $urandom_range(lat_max) : lat_fix;
                    if (fixed0 && cur == 0) begin
                        rsp_resp = 2'd0; rsp_data = 64'hDEAD;
                    end else begin
                        rsp_resp = 2'($urandom); rsp_data = {$urandom, $urandom};
                    end
                end
            end else begin
                dn_cnt++;
            end
        end
        if (w_st) begin
            if (drv_rsp_v) begin
                rspfired = 1; rsp_pend = 0;
                e_resp = dbg_if.resp_bits_resp; e_rdata = dbg_if.resp_bits_data;
            end else if (TO_EN && (cyc - dfire_cyc) == TO) begin
                rspfired = 1; e_resp = 2'b10; e_rdata = 64'h0;
            end
        end
        if (busy_pre && rspfired && !w_st) begin
            if (drv_rr[cur]) begin
                obs_who  = cur;
                obs_resp = (cur == 0) ? r0_if.resp_bits_resp : r1_if.resp_bits_resp;
                obs_data = (cur == 0) ? r0_if.resp_bits_data : r1_if.resp_bits_data;
                ndeliv++;
                busy = 0;
                rr_cnt[cur]   = 0;
                rr_stall[cur] = rnd_stall ? $urandom_range(3) : rr_fix;
            end else begin
                rr_cnt[cur]++;
            end
        end
        if (!busy_pre && any) begin
            busy = 1; dfired = 0; rspfired = 0;
            cur = who; last_gnt = who;
            e_addr = q_addr[who]; e_op = q_op[who]; e_data = q_data[who];
            grants.push_back(who);
            vld[who] = 0;
        end
    endtask

    initial begin
        int start;
        reset_n = 1'b1;
        p_v[0] = 0; p_v[1] = 0; p_drop = 0;
        fixed0 = 0; no_resp = 0; force_rsp = 0;
        vld[0] = 0; vld[1] = 0;
        q_addr[0] = 0; q_addr[1] = 0; q_op[0] = 0; q_op[1] = 0; q_data[0] = 0; q_data[1] = 0;
        rsp_resp = 0; rsp_data = 0; frc_resp = 0; frc_data = 0;
        ndeliv = 0; cur = 0; dfire_cyc = 0;
        set_fix(0, 0, 0);
        #2;
        async_reset();

        // single read from r0, downstream answers in the first WAIT cycle
        fixed0 = 1; p_v[0] = 100; set_fix(0, 0, 0);
        for (int i = 0; i < 50 && ndeliv < 1; i++) step();
        p_v[0] = 0; vld[0] = 0; fixed0 = 0;
        chk("t_basic_done", ndeliv, 1);
        chk("t_basic_who", obs_who, 0);
        chk("t_basic_resp", obs_resp, 0);
        chk("t_basic_data", obs_data, 64'hDEAD);

        // both contend under heavy stalls: r1 is due, fields must hold still
        p_v[0] = 100; p_v[1] = 100; set_fix(5, 3, 2);
        start = ndeliv;
        for (int i = 0; i < 80 && ndeliv < start + 1; i++) step();
        p_v[0] = 0; p_v[1] = 0; vld[0] = 0; vld[1] = 0;
        chk("t_stall_done", ndeliv, start + 1);
        chk("t_stall_who", obs_who, 1);

        // reset while WAITing for a response that never comes
        p_v[0] = 100; no_resp = 1; set_fix(0, 0, 0);
        for (int i = 0; i < 50 && !(busy && dfired); i++) step();
        chk("t_rst_in_wait", busy && dfired, 1);
        step();
        @(posedge clk);
        #3;
        async_reset();
        p_v[0] = 0; no_resp = 0;
        start = ndeliv;
        force_rsp = 1; frc_resp = 2'b01; frc_data = 64'h1234;
        repeat (3) step();
        force_rsp = 0;
        repeat (3) step();
        chk("t_rst_no_deliv", ndeliv, start);

        // continuous contention from reset: strict alternation starting with r0
        grants.delete();
        p_v[0] = 100; p_v[1] = 100; rnd_stall = 1;
        for (int i = 0; i < 200 && grants.size() < 4; i++) step();
        chk("t_rr_count", grants.size() >= 4, 1);
        if (grants.size() >= 4) begin
            chk("t_rr_g0", grants[0], 0);
            chk("t_rr_g1", grants[1], 1);
            chk("t_rr_g2", grants[2], 0);
            chk("t_rr_g3", grants[3], 1);
        end

        // randomized traffic, including requesters withdrawing before grant
        for (int ph = 0; ph < 8; ph++) begin
            p_v[0] = $urandom_range(100); p_v[1] = $urandom_range(100);
            p_drop = $urandom_range(15);
            repeat (200) step();
        end
        p_v[0] = 0; p_v[1] = 0; p_drop = 100;
        repeat (60) step();
        p_drop = 0;
        chk("t_rand_drain", busy, 0);

`ifdef DMI_ARB_TIMEOUT_EN
        // silent downstream: timeout reply, then a late response drained in IDLE
        p_v[0] = 100; no_resp = 1; set_fix(0, 0, 0);
        start = ndeliv;
        for (int i = 0; i < 100 && ndeliv < start + 1; i++) step();
        p_v[0] = 0; vld[0] = 0; no_resp = 0;
        chk("t_to_done", ndeliv, start + 1);
        chk("t_to_resp", obs_resp, 2'b10);
        chk("t_to_data", obs_data, 0);
        force_rsp = 1; frc_resp = 2'b00; frc_data = 64'hBEEF;
        step();
        force_rsp = 0;
        repeat (4) step();
        chk("t_to_late_drop", ndeliv, start + 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dmi_arbiter.md
DMI_ARBITER -- requirements
Module: dmi_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64: DMI data width.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: response timeout limit; used only when DMI_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-005 rN_req_valid  input  1  requester N (N=0,1) request valid.
REQ-006 rN_req_ready  output  1  requester N request accepted.
REQ-007 rN_req_bits_addr/op/data  input  7/2/DATA_WIDTH  requester N DMI address, op, write data.
REQ-008 rN_resp_valid  output  1  response valid to requester N.
REQ-009 rN_resp_ready  input  1  requester N takes the response.
REQ-010 rN_resp_bits_resp/data  output  2/DATA_WIDTH  response code and read data to requester N.
REQ-011 debug_req_valid  output  1  downstream DMI request valid.
REQ-012 debug_req_ready  input  1  downstream accepts the request.
REQ-013 debug_req_bits_addr/op/data  output  7/2/DATA_WIDTH  downstream request fields.
REQ-014 debug_resp_valid  input  1  downstream response valid.
REQ-015 debug_resp_ready  output  1  arbiter accepts the downstream response.
REQ-016 debug_resp_bits_resp/data  input  2/DATA_WIDTH  downstream response fields.

Function
REQ-017 States: IDLE, ISSUE, WAIT, DELIVER; exactly one transaction outstanding at a time.
REQ-018 IDLE: when any rN_req_valid=1, grant one requester; only the granted rN_req_ready=1, for that cycle only. Capture addr/op/data and grant index; next state ISSUE.
REQ-019 Arbitration: round-robin. With both valid, grant the requester not granted last. Last-grant pointer resets to 1, so r0 wins the first contention.
REQ-020 rN_req_ready is 0 in all states other than IDLE.
REQ-021 ISSUE: debug_req_valid=1, fields from capture registers and stable until accepted; on debug_req_ready=1 go to WAIT. Earliest debug_req_valid is the cycle after acceptance.
REQ-022 WAIT: debug_resp_ready=1; on debug_resp_valid=1 capture resp/data and go to DELIVER.
REQ-023 DELIVER: granted rN_resp_valid=1 with captured fields; other requester's resp_valid=0. On rN_resp_ready=1 go to IDLE. New grant is possible no earlier than the following cycle.
REQ-024 debug_resp_ready=0 outside WAIT, except as stated in REQ-031.
REQ-025 Fields are passed through unmodified: no width change or arithmetic on addr/op/data/resp.
REQ-026 A requester that drops req_valid before its grant loses nothing; a grant is never revoked once given.

Reset
REQ-027 Assertion of reset_n=0 forces, immediately: state IDLE; all valid/ready outputs 0; capture registers, debug_req_bits_* and rN_resp_bits_* 0; last-grant pointer 1; timeout counter 0.
REQ-028 Reset mid-transaction abandons it; no response is delivered afterwards. First grant is possible on the first posedge after release.

Configuration
REQ-029 Macro DMI_ARB_TIMEOUT_EN. When undefined, WAIT waits indefinitely and no counter logic exists.
REQ-030 When defined, a counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES with no response, go to DELIVER with resp=2'b10 and data=0.
REQ-031 When defined, debug_resp_ready=1 also in IDLE, and responses arriving in IDLE are discarded, so late responses after a timeout are drained.

Verification
REQ-032 r0 only: read, addr=0x11, op=1; downstream ready immediately, resp=0 and data=0xDEAD one cycle later -> debug_req_valid in cycle after r0_req_ready; r0 gets resp=0, data=0xDEAD; r1_resp_valid stays 0.
REQ-033 Both valid continuously for 4 transactions -> grants r0,r1,r0,r1; each response goes only to its own requester.
REQ-034 debug_req_ready held 0 for 5 cycles, r1_resp_ready held 0 for 3 cycles -> debug_req fields and r1_resp fields stay stable throughout; no second grant occurs.
REQ-035 reset_n pulsed low during WAIT -> all outputs 0 asynchronously; a later debug_resp_valid produces no rN_resp_valid.
REQ-036 With DMI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no downstream response -> requester gets resp=2'b10, data=0 after 8 WAIT cycles; a late response arriving in IDLE is consumed and dropped.
